motor_apb_master: RTL and testbench
===================================

MOTOR_APB_MASTER -- requirements
Module: motor_apb_master

Interface
REQ-001 Parameter TIMEOUT, default 255: maximum ACCESS-phase cycles before a transfer is abandoned.
REQ-002 clk  input  1  single clock; all logic on posedge clk.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 cmd_valid  input  1  command request.
REQ-005 cmd_ready  output  1  block can accept a command.
REQ-006 cmd_write  input  1  1 = APB write, 0 = APB read.
REQ-007 cmd_wait  input  1  1 = wait-for-fabint command; no bus transfer; overrides cmd_write.
REQ-008 cmd_addr  input  32  transfer address.
REQ-009 cmd_wdata  input  32  write data.
REQ-010 rsp_valid  output  1  response available.
REQ-011 rsp_ready  input  1  response consumed.
REQ-012 rsp_rdata  output  32  captured prdata; 0 for writes and waits.
REQ-013 rsp_error  output  1  slave error or timeout.
REQ-014 rsp_timeout  output  1  transfer abandoned by timeout.
REQ-015 psel, penable, pwrite  output  1 each  APB control toward motor_mmio_handler.
REQ-016 paddr, pwdata  output  32 each  APB address and write data.
REQ-017 prdata  input  32  APB read data.
REQ-018 ready, error  input  1 each  APB slave ready and slave error.
REQ-019 fabint  input  1  motor-done interrupt from the MMIO handler.

Function
REQ-020 FSM states: IDLE, SETUP, ACCESS, WAIT_INT, RESP.
REQ-021 cmd_ready = 1 only in IDLE; accept when cmd_valid && cmd_ready; latch cmd_write, cmd_addr, cmd_wdata, cmd_wait.
REQ-022 IDLE -> SETUP on bus accept; IDLE -> WAIT_INT on wait accept.
REQ-023 SETUP lasts exactly one cycle: psel=1, penable=0, paddr/pwrite/pwdata valid -> ACCESS.
REQ-024 ACCESS: psel=1, penable=1, paddr/pwrite/pwdata held stable; remain until ready=1 sampled.
REQ-025 On ready=1 in ACCESS: capture prdata (reads only) and error into rsp_error -> RESP; psel=penable=0 from the next cycle.
REQ-026 Timeout counter cleared on SETUP entry, increments each ACCESS cycle with ready=0; on reaching TIMEOUT: rsp_error=1, rsp_timeout=1, rsp_rdata=0 -> RESP.
REQ-027 ready=1 in the cycle the counter reaches TIMEOUT: ready wins, no timeout.
REQ-028 WAIT_INT: fabint_q registered each cycle; on WAIT_INT entry fabint_q loads current fabint; complete on fabint=1 && fabint_q=0 -> RESP with rsp_error=0. fabint already high at entry is not an edge; no timeout in WAIT_INT.
REQ-029 RESP: rsp_valid=1 and rsp_* held stable until rsp_ready=1 -> IDLE next cycle; no new command accepted in the rsp_ready cycle.
REQ-030 Write latency with ready tied 1: accept cycle N, SETUP N+1, ACCESS N+2, rsp_valid N+3.
REQ-031 psel, penable, pwrite, paddr and pwdata are registered outputs and glitch-free; psel=0 implies penable=0.

Reset
REQ-032 reset forces IDLE in any state, including mid-ACCESS; the transfer is abandoned with no response.
REQ-033 Reset values: cmd_ready=1 (after the first cycle in IDLE), rsp_valid=0, rsp_rdata=0, rsp_error=0, rsp_timeout=0, psel=0, penable=0, pwrite=0, paddr=0, pwdata=0, timeout counter=0, fabint_q=0.

Structure
REQ-034 Shared package motor_pkg holds the FSM state enum, the MMIO register offsets (CMD=0, COUNT=4) and the TIMEOUT default.
REQ-035 Single module; no sub-module. The timeout counter width is clog2(TIMEOUT+1).

Verification
REQ-036 Write addr=4 data=5, ready=1 -> SETUP then ACCESS one cycle each, rsp_valid at N+3, rsp_error=0.
REQ-037 Read addr=0, ready low 3 ACCESS cycles, prdata=0xA5 -> ACCESS lasts 4 cycles, rsp_rdata=0xA5.
REQ-038 Read with ready=0 forever, TIMEOUT=8 -> rsp_valid after 8 ACCESS cycles, rsp_error=1, rsp_timeout=1, psel drops.
REQ-039 Wait command, fabint high at entry, then low 2 cycles, then high -> response only on the later rising edge.
REQ-040 Write with error=1 and ready=1 -> rsp_error=1, rsp_timeout=0; rsp held 5 cycles with rsp_ready=0, unchanged.
REQ-041 reset asserted in ACCESS -> next cycle psel=0, penable=0, rsp_valid=0, cmd_ready=1.

Source files
------------

// File: rtl/motor_pkg.sv
// Shared definitions for the motor control APB master.
// FSM state encoding, MMIO register offsets and timeout default.
package motor_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_WAIT_INT,
        ST_RESP
    } state_t;

    localparam logic [31:0] REG_CMD   = 32'h0000_0000;
    localparam logic [31:0] REG_COUNT = 32'h0000_0004;

    localparam int TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/motor_apb_master.sv
// Command-driven APB master toward the motor MMIO handler.
// Runs one APB transfer or waits for a fabint rising edge per command.
module motor_apb_master
    import motor_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic        cmd_wait,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error,
    output logic        rsp_timeout,
    output logic        psel,
    output logic        penable,
    output logic        pwrite,
    output logic [31:0] paddr,
    output logic [31:0] pwdata,
    input  logic [31:0] prdata,
    input  logic        ready,
    input  logic        error,
    input  logic        fabint
);

    localparam int CW = $clog2(TIMEOUT + 1);

    state_t          state;
    state_t          state_next;
    logic [CW-1:0]   tmo_cnt;
    logic [CW-1:0]   tmo_next;
    logic            tmo_hit;
    logic            fabint_q;
    logic            accept;
    logic            fab_rise;

    assign cmd_ready = (state == ST_IDLE);
    assign rsp_valid = (state == ST_RESP);
    assign accept    = cmd_valid && cmd_ready;
    assign tmo_next  = tmo_cnt + CW'(1);
    assign tmo_hit   = (tmo_next == CW'(TIMEOUT));
    assign fab_rise  = fabint && !fabint_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_next = cmd_wait ? ST_WAIT_INT : ST_SETUP;
                end
            end
            ST_SETUP: state_next = ST_ACCESS;
            ST_ACCESS: begin
                if (ready || tmo_hit) begin
                    state_next = ST_RESP;
                end
            end
            ST_WAIT_INT: begin
                if (fab_rise) begin
                    state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Bus signals and response fields are all registered so nothing glitches.
    always_ff @(posedge clk) begin
        if (reset) begin
            psel        <= 1'b0;
            penable     <= 1'b0;
            pwrite      <= 1'b0;
            paddr       <= '0;
            pwdata      <= '0;
            rsp_rdata   <= '0;
            rsp_error   <= 1'b0;
            rsp_timeout <= 1'b0;
            tmo_cnt     <= '0;
            fabint_q    <= 1'b0;
        end else begin
            fabint_q <= fabint;
            unique case (state)
                ST_IDLE: begin
                    if (accept) begin
                        rsp_rdata   <= '0;
                        rsp_error   <= 1'b0;
                        rsp_timeout <= 1'b0;
                        if (!cmd_wait) begin
                            psel    <= 1'b1;
                            pwrite  <= cmd_write;
                            paddr   <= cmd_addr;
                            pwdata  <= cmd_wdata;
                            tmo_cnt <= '0;
                        end
                    end
                end
                ST_SETUP: penable <= 1'b1;
                ST_ACCESS: begin
                    if (ready) begin
                        psel      <= 1'b0;
                        penable   <= 1'b0;
                        rsp_error <= error;
                        if (!pwrite) begin
                            rsp_rdata <= prdata;
                        end
                    end else if (tmo_hit) begin
                        psel        <= 1'b0;
                        penable     <= 1'b0;
                        rsp_error   <= 1'b1;
                        rsp_timeout <= 1'b1;
                        rsp_rdata   <= '0;
                        tmo_cnt     <= tmo_next;
                    end else begin
                        tmo_cnt <= tmo_next;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_motor_apb_master.sv
// Directed self-checking bench for motor_apb_master.
// Inputs change and outputs are sampled on the falling edge.
module tb_motor_apb_master;

    logic        clk;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic        cmd_wait;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_error;
    logic        rsp_timeout;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        ready;
    logic        error;
    logic        fabint;

    int tests;
    int failed;

    motor_apb_master #(.TIMEOUT(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_write  (cmd_write),
        .cmd_wait   (cmd_wait),
        .cmd_addr   (cmd_addr),
        .cmd_wdata  (cmd_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_error  (rsp_error),
        .rsp_timeout(rsp_timeout),
        .psel       (psel),
        .penable    (penable),
        .pwrite     (pwrite),
        .paddr      (paddr),
        .pwdata     (pwdata),
        .prdata     (prdata),
        .ready      (ready),
        .error      (error),
        .fabint     (fabint)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present a command for exactly one cycle; DUT must be idle.
    task automatic issue(input logic wr, input logic wt,
                         input logic [31:0] a, input logic [31:0] d);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_wait  = wt;
        cmd_addr  = a;
        cmd_wdata = d;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic consume();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        tests++;
        if ({psel, penable, pwrite, rsp_valid, rsp_error, rsp_timeout}
            !== 6'b0) begin
            failed++;
            $display("FAIL reset_ctrl got %b want 000000",
                     {psel, penable, pwrite, rsp_valid,
                      rsp_error, rsp_timeout});
        end
        tests++;
        if ({paddr, pwdata, rsp_rdata} !== 96'b0) begin
            failed++;
            $display("FAIL reset_data paddr=%h pwdata=%h rdata=%h want 0",
                     paddr, pwdata, rsp_rdata);
        end
        reset = 1'b0;
        @(negedge clk);
        tests++;
        if (cmd_ready !== 1'b1) begin
            failed++;
            $display("FAIL reset_cmd_ready got %b want 1", cmd_ready);
        end
    endtask

    task automatic test_write();
        ready = 1'b1;
        error = 1'b0;
        issue(1'b1, 1'b0, 32'h4, 32'h5);
        tests++;
        if ({psel, penable, pwrite, cmd_ready} !== 4'b1010) begin
            failed++;
            $display("FAIL wr_setup psel/pen/pwr/crdy got %b want 1010",
                     {psel, penable, pwrite, cmd_ready});
        end
        tests++;
        if (paddr !== 32'h4 || pwdata !== 32'h5) begin
            failed++;
            $display("FAIL wr_setup_bus paddr=%h pwdata=%h want 4/5",
                     paddr, pwdata);
        end
        @(negedge clk);
        tests++;
        if ({psel, penable, rsp_valid} !== 3'b110) begin
            failed++;
            $display("FAIL wr_access psel/pen/rv got %b want 110",
                     {psel, penable, rsp_valid});
        end
        @(negedge clk);
        tests++;
        if ({rsp_valid, rsp_error, rsp_timeout, psel, penable}
            !== 5'b10000 || rsp_rdata !== 32'h0) begin
            failed++;
            $display("FAIL wr_resp rv/err/tmo/psel/pen got %b rdata=%h want 10000/0",
                     {rsp_valid, rsp_error, rsp_timeout, psel, penable},
                     rsp_rdata);
        end
        consume();
        tests++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            failed++;
            $display("FAIL wr_done rv=%b crdy=%b want 0/1",
                     rsp_valid, cmd_ready);
        end
    endtask

    task automatic test_read_wait();
        int acc;
        acc    = 0;
        ready  = 1'b0;
        prdata = 32'hA5;
        issue(1'b0, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (penable) begin
                acc++;
                if (acc == 4) ready = 1'b1;
            end else if (rsp_valid) begin
                break;
            end
        end
        ready = 1'b0;
        tests++;
        if (acc !== 4) begin
            failed++;
            $display("FAIL rd_access_len got %0d want 4", acc);
        end
        tests++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hA5
            || rsp_error !== 1'b0) begin
            failed++;
            $display("FAIL rd_resp rv=%b rdata=%h err=%b want 1/a5/0",
                     rsp_valid, rsp_rdata, rsp_error);
        end
        consume();
    endtask

    task automatic test_timeout(input logic late_ready);
        int acc;
        acc    = 0;
        ready  = 1'b0;
        prdata = 32'hDEAD_BEEF;
        issue(1'b0, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (penable) begin
                acc++;
                if (acc == 8 && late_ready) ready = 1'b1;
            end else if (rsp_valid) begin
                break;
            end
        end
        ready = 1'b0;
        tests++;
        if (acc !== 8) begin
            failed++;
            $display("FAIL tmo_access_len late=%b got %0d want 8",
                     late_ready, acc);
        end
        if (late_ready) begin
            tests++;
            if ({rsp_valid, rsp_error, rsp_timeout} !== 3'b100
                || rsp_rdata !== 32'hDEAD_BEEF) begin
                failed++;
                $display("FAIL tmo_ready_wins rv/err/tmo=%b rdata=%h want 100/deadbeef",
                         {rsp_valid, rsp_error, rsp_timeout}, rsp_rdata);
            end
        end else begin
            tests++;
            if ({rsp_valid, rsp_error, rsp_timeout, psel} !== 4'b1110
                || rsp_rdata !== 32'h0) begin
                failed++;
                $display("FAIL tmo_resp rv/err/tmo/psel=%b rdata=%h want 1110/0",
                         {rsp_valid, rsp_error, rsp_timeout, psel},
                         rsp_rdata);
            end
        end
        consume();
    endtask

    task automatic test_wait_int();
        fabint = 1'b1;
        @(negedge clk);
        issue(1'b1, 1'b1, 32'h4, 32'h9);
        tests++;
        if ({psel, cmd_ready, rsp_valid} !== 3'b000) begin
            failed++;
            $display("FAIL wait_entry psel/crdy/rv got %b want 000",
                     {psel, cmd_ready, rsp_valid});
        end
        @(negedge clk);
        tests++;
        if (rsp_valid !== 1'b0) begin
            failed++;
            $display("FAIL wait_high_no_edge rv=%b want 0", rsp_valid);
        end
        fabint = 1'b0;
        repeat (2) @(negedge clk);
        tests++;
        if (rsp_valid !== 1'b0) begin
            failed++;
            $display("FAIL wait_low rv=%b want 0", rsp_valid);
        end
        fabint = 1'b1;
        @(negedge clk);
        tests++;
        if ({rsp_valid, rsp_error, rsp_timeout} !== 3'b100
            || rsp_rdata !== 32'h0) begin
            failed++;
            $display("FAIL wait_resp rv/err/tmo=%b rdata=%h want 100/0",
                     {rsp_valid, rsp_error, rsp_timeout}, rsp_rdata);
        end
        fabint = 1'b0;
        consume();
    endtask

    task automatic test_error_hold();
        ready = 1'b1;
        error = 1'b1;
        issue(1'b1, 1'b0, 32'h0, 32'h77);
        repeat (2) @(negedge clk);
        ready = 1'b0;
        error = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tests++;
            if ({rsp_valid, rsp_error, rsp_timeout} !== 3'b110
                || rsp_rdata !== 32'h0) begin
                failed++;
                $display("FAIL err_hold[%0d] rv/err/tmo=%b rdata=%h want 110/0",
                         i, {rsp_valid, rsp_error, rsp_timeout}, rsp_rdata);
            end
            @(negedge clk);
        end
        consume();
    endtask

    task automatic test_reset_mid();
        ready = 1'b0;
        issue(1'b0, 1'b0, 32'h4, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        tests++;
        if ({psel, penable, rsp_valid, cmd_ready} !== 4'b0001) begin
            failed++;
            $display("FAIL rst_mid psel/pen/rv/crdy got %b want 0001",
                     {psel, penable, rsp_valid, cmd_ready});
        end
        @(negedge clk);
        tests++;
        if (rsp_valid !== 1'b0 || psel !== 1'b0) begin
            failed++;
            $display("FAIL rst_mid_after rv=%b psel=%b want 0/0",
                     rsp_valid, psel);
        end
    endtask

    task automatic test_back_to_back();
        ready = 1'b1;
        error = 1'b0;
        prdata = 32'h1234_5678;
        issue(1'b1, 1'b0, 32'h0, 32'h3);
        repeat (2) @(negedge clk);
        rsp_ready = 1'b1;
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_wait  = 1'b0;
        cmd_addr  = 32'h4;
        @(negedge clk);
        rsp_ready = 1'b0;
        tests++;
        if ({cmd_ready, psel, rsp_valid} !== 3'b100) begin
            failed++;
            $display("FAIL b2b_no_accept crdy/psel/rv got %b want 100",
                     {cmd_ready, psel, rsp_valid});
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        tests++;
        if ({psel, penable, pwrite} !== 3'b100 || paddr !== 32'h4) begin
            failed++;
            $display("FAIL b2b_setup psel/pen/pwr=%b paddr=%h want 100/4",
                     {psel, penable, pwrite}, paddr);
        end
        repeat (2) @(negedge clk);
        tests++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h1234_5678) begin
            failed++;
            $display("FAIL b2b_resp rv=%b rdata=%h want 1/12345678",
                     rsp_valid, rsp_rdata);
        end
        ready = 1'b0;
        consume();
    endtask

    initial begin
        tests     = 0;
        failed    = 0;
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_wait  = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        rsp_ready = 1'b0;
        prdata    = '0;
        ready     = 1'b0;
        error     = 1'b0;
        fabint    = 1'b0;
        test_reset();
        test_write();
        test_read_wait();
        test_timeout(1'b0);
        test_timeout(1'b1);
        test_wait_int();
        test_error_hold();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
